// File: rtl/conv_mac_pkg.sv
// -----------------------------------------------------------------------------
// conv_mac_pkg
// Shared definitions for the convolution MAC accumulator:
//   KERNEL_LEN_DEF / MUL_LATENCY_DEF : default taps per window and multiplier
//                                      latency
//   acc_width(taps)                  : accumulator width that holds a sum of
//                                      'taps' 16-bit products without loss
//   conv_result_t                    : one finished window {sum, taps}
// -----------------------------------------------------------------------------
package conv_mac_pkg;

   localparam int KERNEL_LEN_DEF  = 9;
   localparam int MUL_LATENCY_DEF = 4;

   function automatic int acc_width(input int taps);
      return 16 + $clog2(taps);
   endfunction

   localparam int ACC_W_DEF  = acc_width(KERNEL_LEN_DEF);
   localparam int TAPS_W_DEF = $clog2(KERNEL_LEN_DEF + 1) + 1;

   // Sized for the default kernel; the top level is built with matching widths.
   typedef struct packed {
      logic [ACC_W_DEF-1:0]  sum;
      logic [TAPS_W_DEF-1:0] taps;
   } conv_result_t;

endpackage

// File: rtl/conv_result_fifo.sv
// -----------------------------------------------------------------------------
// conv_result_fifo
// Two-entry register FIFO holding finished window results.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push_valid_i  : write push_data_i this cycle
//   push_data_i   : result to store
//   pop_ready_i   : consumer takes the head entry this cycle
//   pop_valid_o   : head entry is valid
//   pop_data_o    : head entry (stable until popped)
//   count_o       : number of stored entries (0..2)
// Handshake: an entry leaves when pop_valid_o & pop_ready_i at a rising edge;
// push and pop on the same edge leave the count unchanged.
// -----------------------------------------------------------------------------
module conv_result_fifo
   import conv_mac_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_valid_i,
   input  conv_result_t push_data_i,
   input  logic         pop_ready_i,
   output logic         pop_valid_o,
   output conv_result_t pop_data_o,
   output logic [1:0]   count_o
);

   conv_result_t mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic         push;
   logic         pop;

   assign pop  = pop_ready_i & (count_q != 2'd0);
   // A push into a full FIFO is only taken when the head leaves on the same edge.
   assign push = push_valid_i & ((count_q != 2'd2) | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign pop_valid_o = (count_q != 2'd0);
   assign pop_data_o  = mem_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

// File: rtl/conv_mac_accumulator.sv
// -----------------------------------------------------------------------------
// conv_mac_accumulator
// Sums unsigned 8x8 products from an external pipelined multiplier into
// per-window convolution results.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand beat handshake (beat fires on valid & ready)
//   in_a, in_b, in_last  : operands and end-of-window marker
//   mul_a, mul_b         : operands to the multiplier (combinational copies)
//   mul_p                : product, MUL_LATENCY cycles after the operands
//   out_valid/out_ready  : result handshake (result pops on valid & ready)
//   out_sum, out_taps    : window sum and number of taps in that window
//   err_len              : sticky, a window ended with taps != KERNEL_LEN
// Handshakes are valid/ready: a transfer happens on a rising edge where both
// are high; a source holds its payload stable while valid is high and ready low.
// -----------------------------------------------------------------------------
module conv_mac_accumulator
   import conv_mac_pkg::*;
#(
   parameter int KERNEL_LEN  = KERNEL_LEN_DEF,
   parameter int MUL_LATENCY = MUL_LATENCY_DEF,
   parameter int ACC_W       = acc_width(KERNEL_LEN)
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [7:0]                    in_a,
   input  logic [7:0]                    in_b,
   input  logic                          in_last,
   output logic [7:0]                    mul_a,
   output logic [7:0]                    mul_b,
   input  logic [15:0]                   mul_p,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_W-1:0]              out_sum,
   output logic [$clog2(KERNEL_LEN+1):0] out_taps,
   output logic                          err_len
);

   localparam int TAPS_W = $clog2(KERNEL_LEN + 1) + 1;
   localparam logic [TAPS_W-1:0] TAPS_MAX  = '1;
   localparam logic [TAPS_W-1:0] TAPS_KERN = TAPS_W'(KERNEL_LEN);

   logic                   fire;
   // Tag delay line: bit i of each vector is stage i.
   logic [MUL_LATENCY-1:0] tag_vld_q;
   logic [MUL_LATENCY-1:0] tag_last_q;
   // Product and tag registered together at the multiplier boundary.
   logic                   ex_vld_q;
   logic                   ex_last_q;
   logic [15:0]            ex_p_q;
   logic [ACC_W-1:0]       acc_q;
   logic [ACC_W-1:0]       sum_d;
   logic [TAPS_W-1:0]      taps_q;
   logic [TAPS_W-1:0]      taps_d;
   logic                   err_q;
   logic [7:0]             lasts_in_line;
   logic [1:0]             buf_count;
   logic                   push;
   conv_result_t           push_data;
   conv_result_t           head;

   assign mul_a = in_a;
   assign mul_b = in_b;
   assign fire  = in_valid & in_ready;

   // Every last beat in flight owns one buffer slot, so the buffer never fills
   // past two. All beats stall while credit is gone, which keeps the ordering
   // rule simple for the upstream source.
   always_comb begin
      lasts_in_line = {7'd0, ex_last_q};
      for (int i = 0; i < MUL_LATENCY; i++) begin
         lasts_in_line = lasts_in_line + {7'd0, tag_last_q[i]};
      end
   end

   assign in_ready = (lasts_in_line + {6'd0, buf_count}) < 8'd2;

   always_comb begin
      taps_d = (taps_q == TAPS_MAX) ? taps_q : taps_q + 1'b1;
      sum_d  = (taps_q == '0) ? {{(ACC_W-16){1'b0}}, ex_p_q}
                              : acc_q + {{(ACC_W-16){1'b0}}, ex_p_q};
   end

   assign push           = ex_vld_q & ex_last_q;
   assign push_data.sum  = sum_d;
   assign push_data.taps = taps_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         ex_vld_q   <= 1'b0;
         ex_last_q  <= 1'b0;
         ex_p_q     <= '0;
         acc_q      <= '0;
         taps_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         tag_vld_q  <= {tag_vld_q[MUL_LATENCY-2:0], fire};
         tag_last_q <= {tag_last_q[MUL_LATENCY-2:0], fire & in_last};
         ex_vld_q   <= tag_vld_q[MUL_LATENCY-1];
         ex_last_q  <= tag_vld_q[MUL_LATENCY-1] & tag_last_q[MUL_LATENCY-1];
         ex_p_q     <= mul_p;
         if (ex_vld_q) begin
            if (ex_last_q) begin
               acc_q  <= '0;
               taps_q <= '0;
               if (taps_d != TAPS_KERN) begin
                  err_q <= 1'b1;
               end
            end else begin
               acc_q  <= sum_d;
               taps_q <= taps_d;
            end
         end
      end
   end

   conv_result_fifo u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_valid_i (push),
      .push_data_i  (push_data),
      .pop_ready_i  (out_ready),
      .pop_valid_o  (out_valid),
      .pop_data_o   (head),
      .count_o      (buf_count)
   );

   assign out_sum  = head.sum;
   assign out_taps = head.taps;
   assign err_len  = err_q;

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_conv_mac_accumulator
// Drives operand beats into conv_mac_accumulator with a behavioural 4-stage
// multiplier and checks every delivered result against an expected queue.
// -----------------------------------------------------------------------------
module tb_conv_mac_accumulator;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        in_last;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_sum;
   logic [4:0]  out_taps;
   logic        err_len;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   conv_mac_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_taps  (out_taps),
      .err_len   (err_len)
   );

   // Behavioural multiplier: operands sampled at an edge, product 4 cycles on.
   // Deliberately not reset so stale products keep flowing after a reset.
   logic [15:0] mul_pipe [4];
   always @(posedge clk) begin
      mul_pipe[0] <= mul_a * mul_b;
      for (int i = 1; i < 4; i++) mul_pipe[i] <= mul_pipe[i-1];
   end
   assign mul_p = mul_pipe[3];

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [24:0] exp_q[$];   // {sum[19:0], taps[4:0]}

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      logic [24:0] e;
      #2;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum=%0d taps=%0d, required no result", out_sum, out_taps);
         end else begin
            e = exp_q.pop_front();
            check("out_sum", out_sum, e[24:5]);
            check("out_taps", out_taps, e[4:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   int last_fire_cyc = 0;
   int stall_cnt = 0;

   // Called at a falling edge; returns at the falling edge after the beat fired.
   task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
         stall_cnt++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, guard);
      end else begin
         @(posedge clk);
         @(negedge clk);
         last_fire_cyc = cyc;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // ---------------- table of back-to-back 9-tap windows ----------------
   typedef struct {
      logic [7:0]  a0;
      logic [7:0]  a_step;
      logic [7:0]  b;
      logic [19:0] exp_sum;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int t0;
      int tf;
      int s0;
      int stable;
      logic [7:0] a_i;

      vecs[0] = '{a0: 8'd1,   a_step: 8'd1,  b: 8'd1,   exp_sum: 20'd45};
      vecs[1] = '{a0: 8'd2,   a_step: 8'd0,  b: 8'd3,   exp_sum: 20'd54};
      vecs[2] = '{a0: 8'd10,  a_step: 8'd0,  b: 8'd10,  exp_sum: 20'd900};
      vecs[3] = '{a0: 8'd0,   a_step: 8'd30, b: 8'd7,   exp_sum: 20'd7560};
      vecs[4] = '{a0: 8'd255, a_step: 8'd0,  b: 8'd0,   exp_sum: 20'd0};
      vecs[5] = '{a0: 8'd255, a_step: 8'd0,  b: 8'd255, exp_sum: 20'd585225};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 8'h5A;
      in_b      = 8'hC3;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_taps", out_taps, 0);
      check("rst_err_len", err_len, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_mul_a", mul_a, 8'h5A);
      check("rst_mul_b", mul_b, 8'hC3);
      rst = 1'b0;
      @(negedge clk);

      // Full-scale window and latency from the last fire to out_valid
      out_ready = 1'b1;
      exp_q.push_back({20'd585225, 5'd9});
      for (int i = 0; i < 9; i++) send_beat(8'd255, 8'd255, i == 8);
      t0 = last_fire_cyc;
      while (!out_valid && cyc < t0 + 20) @(negedge clk);
      check("latency", cyc - t0, 5);
      drain("drain_full_scale");
      check("err_full_scale", err_len, 0);

      // Back-to-back windows from the table, no gap cycles
      s0 = stall_cnt;
      for (int v = 0; v < 6; v++) begin
         exp_q.push_back({vecs[v].exp_sum, 5'd9});
         for (int i = 0; i < 9; i++) begin
            a_i = vecs[v].a0 + 8'(i) * vecs[v].a_step;
            send_beat(a_i, vecs[v].b, i == 8);
         end
      end
      check("b2b_in_ready_stalls", stall_cnt - s0, 0);
      drain("drain_table");
      check("err_table", err_len, 0);

      // Simultaneous push and pop with one entry buffered
      out_ready = 1'b0;
      exp_q.push_back({20'd9, 5'd9});
      exp_q.push_back({20'd36, 5'd9});
      for (int i = 0; i < 9; i++) send_beat(8'd1, 8'd1, i == 8);
      for (int i = 0; i < 9; i++) send_beat(8'd2, 8'd2, i == 8);
      tf = last_fire_cyc;
      wait_cyc(tf + 4);
      check("pp_before_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_cyc(tf + 5);
      check("pp_count_one", out_valid, 1);
      check("pp_in_ready", in_ready, 1);
      check("pp_new_head", out_sum, 36);
      wait_cyc(tf + 6);
      check("pp_empty_after", out_valid, 0);
      drain("drain_pushpop");

      // Short window: one tap, err_len rises with the push and sticks
      exp_q.push_back({20'd21, 5'd1});
      send_beat(8'd3, 8'd7, 1'b1);
      tf = last_fire_cyc;
      wait_cyc(tf + 4);
      check("short_err_before", err_len, 0);
      wait_cyc(tf + 5);
      check("short_err_after", err_len, 1);
      check("short_valid", out_valid, 1);
      drain("drain_short");

      // Back-pressure: three 1-tap windows with the consumer stalled
      out_ready = 1'b0;
      exp_q.push_back({20'd1, 5'd1});
      exp_q.push_back({20'd2, 5'd1});
      exp_q.push_back({20'd3, 5'd1});
      send_beat(8'd1, 8'd1, 1'b1);
      t0 = last_fire_cyc;
      send_beat(8'd2, 8'd1, 1'b1);
      check("bp_in_ready_low", in_ready, 0);
      fork
         send_beat(8'd3, 8'd1, 1'b1);
         begin
            wait_cyc(t0 + 7);
            stable = 1;
            for (int k = 0; k < 4; k++) begin
               if (!(out_valid && out_sum == 20'd1 && out_taps == 5'd1 && !in_ready)) stable = 0;
               @(negedge clk);
            end
            check("bp_hold_stable", stable, 1);
            out_ready = 1'b1;
         end
      join
      drain("drain_backpressure");
      check("err_sticky", err_len, 1);

      // Reset in the middle of a window, with products in flight
      for (int i = 0; i < 4; i++) send_beat(8'd50, 8'd50, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_sum", out_sum, 0);
      check("midrst_err_len", err_len, 0);
      check("midrst_in_ready", in_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back({20'd900, 5'd9});
      for (int i = 0; i < 9; i++) send_beat(8'd10, 8'd10, i == 8);
      drain("drain_after_reset");
      repeat (10) @(negedge clk);
      check("err_clean_window", err_len, 0);

      // Overflow: 17 taps of 255x255 wrap modulo 2^20
      exp_q.push_back({20'd56849, 5'd17});
      for (int i = 0; i < 17; i++) send_beat(8'd255, 8'd255, i == 16);
      drain("drain_overflow");
      check("err_overflow", err_len, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation reached %0t, required finish earlier", $time);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/conv_mac_accumulator.md
# conv_mac_accumulator

Accumulates the 16-bit unsigned products from the 8x8 Vedic multiplier into per-window convolution sums. It sits directly downstream of the multiplier.
- Upstream beats pass through it: it forwards the operands to the multiplier and tags each accepted beat.
- The tags travel through a delay line matched to the multiplier latency, so each tag meets its product.
- Finished window sums go into a 2-entry output buffer with valid/ready handshake.
- Credit-based back-pressure prevents buffer overflow while products are in flight.

## Interface
Parameters:
- KERNEL_LEN, 9: expected taps per window (3x3 kernel).
- MUL_LATENCY, 4: cycles from operands at the multiplier inputs to the matching product on `mul_p`.
- ACC_W, 16+$clog2(KERNEL_LEN) (=20): accumulator and result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  8  sample operand.
- in_b  in  8  coefficient operand.
- in_last  in  1  beat is the last tap of its window.
- mul_a  out  8  to multiplier A; combinational copy of in_a.
- mul_b  out  8  to multiplier B; combinational copy of in_b.
- mul_p  in  16  multiplier product.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  window sum.
- out_taps  out  $clog2(KERNEL_LEN+1)+1  tap count of that window.
- err_len  out  1  sticky: a window ended with a tap count other than KERNEL_LEN.

## Operation
- **Fire:** a beat is accepted when `in_valid & in_ready`.
- **Tag delay line:** MUL_LATENCY stages, each holding {vld, last}.
  - On fire, a tag {1, in_last} is pushed into the line; otherwise {0, 0} is pushed.
  - Products whose tag has vld=0 are ignored. The multiplier runs every cycle.
- **Accumulation**, when the tag leaving the line has vld=1:
  - If the tap counter is 0, the next sum is `mul_p`; otherwise it is `acc + mul_p`.
  - Arithmetic is unsigned, modulo 2^ACC_W.
  - The tap counter increments and saturates at its maximum.
- **End of window**, when the exiting tag also has last=1:
  - The pair {next sum, taps} is pushed into the output buffer.
  - The accumulator and tap counter clear.
  - If taps ≠ KERNEL_LEN, err_len is set.
- **Overflow:** when taps exceed KERNEL_LEN, err_len is set at end of window. The sum is still delivered, wrapped modulo 2^ACC_W.
- **Credit:** `in_ready = (lasts_in_line + buf_count) < 2`.
  - The output buffer therefore never overflows.
  - in_ready is held low for all beats, not only last beats, while credit is exhausted.
- **Output handshake:** a result pops when `out_valid & out_ready`.
  - Simultaneous push and pop is legal; the count is unchanged.
  - out_sum and out_taps hold stable while out_valid=1 and out_ready=0.

## Timing
- **Reset values** of all outputs and state:
  - out_valid=0, out_sum=0, out_taps=0, err_len=0, in_ready=1.
  - Accumulator, tap counter, delay line and buffer are cleared.
  - mul_a and mul_b follow the inputs.
- **Reset mid-operation:** partial sums and in-flight tags are discarded. Products arriving after reset release are ignored because their tags are 0.
- **Latency:** a last beat fired at edge t gives out_valid=1 after edge t+MUL_LATENCY+1 (5 cycles at default).
- **Throughput:** one beat per cycle while credit is available. Back-to-back windows need no gap cycles.
- **Credit timing:** in_ready is combinational from registered counts. A pop at edge t frees credit from cycle t+1.
- **err_len** asserts after the same edge that pushes the offending result.

## Structure
- **Package `conv_mac_pkg`:**
  - KERNEL_LEN_DEF and MUL_LATENCY_DEF.
  - A function `acc_width(taps)` returning 16+$clog2(taps).
  - The result struct typedef {sum, taps}.
- **Sub-module `conv_result_fifo`:** 2-entry register FIFO with push/pop, count and valid/ready. It holds the result struct.
- **Top level** keeps the tag delay line, the accumulator and the credit logic.

## Test plan
- **Full-scale window:** 9 beats of 255×255, last on beat 9. Result: out_sum=585225 (0x8EE09), out_taps=9, err_len=0, out_valid exactly 5 cycles after the last fire.
- **Back-to-back windows, no gaps:**
  - Window 1: taps a=1..9, b=1; result 45.
  - Window 2: a=2, b=3 for all 9 taps; result 54.
  - Both results delivered in order; in_ready stays 1 with out_ready=1.
- **Short window:** a single beat 3×7 with last. Result: out_sum=21, out_taps=1, err_len=1 and it stays 1 until rst.
- **Back-pressure:**
  - With out_ready=0, drive three 1-tap windows (values 1, 2, 3).
  - in_ready drops once two lasts are in flight or buffered; no beat is lost.
  - After releasing out_ready, results 1, 2, 3 appear in order, each held stable while stalled.
- **Reset mid-window:** assert rst after 4 of 9 taps, then run a clean window of 9×(10×10). out_sum=900, out_taps=9, and no stale result appears.
- **Simultaneous push/pop:** buffer holds 1 entry, out_ready=1, and a new result arrives on the same edge. Count stays 1 and in_ready stays 1.
